id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter PC_WIDTH, default 8, width of the program-counter field carried with each instruction.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  taken-branch kill; discards all held instructions.
REQ-005 if_valid  input  1  fetch presents an instruction.
REQ-006 if_instr  input  8  instruction word: [7:4] opcode, [3:2] rd, [1:0] rs.
REQ-007 if_pc  input  PC_WIDTH  address of if_instr.
REQ-008 if_ready  output  1  stage can accept; a transfer occurs when if_valid and if_ready are both high.
REQ-009 id_valid  output  1  decoded instruction is presented downstream.
REQ-010 id_ready  input  1  execute accepts; a transfer occurs when id_valid and id_ready are both high.
REQ-011 id_opcode  output  4  opcode, drives the ALU-control opcode input directly.
REQ-012 id_rd, id_rs  output  2 each  destination and source register indices.
REQ-013 id_imm  output  4  immediate, equal to instr[3:0].
REQ-014 id_pc  output  PC_WIDTH  PC of the presented instruction.
REQ-015 id_is_alu  output  1  high when id_opcode is one of 0001, 0011, 0100, 0101, 0110, 0111, 1000, 1001.

Function
REQ-016 The stage shall be a two-entry skid buffer: main register (presented) plus skid register.
REQ-017 State machine EMPTY / ONE / FULL, encoded by the occupancy of the two entries.
REQ-018 if_ready shall be a registered signal, high in EMPTY and ONE, low in FULL; it shall not depend combinationally on id_ready.
REQ-019 EMPTY: upstream transfer -> ONE, instruction enters main; id_valid rises the next cycle (latency 1).
REQ-020 ONE: upstream and downstream transfer together -> stay ONE, main replaced by new instruction.
REQ-021 ONE: downstream transfer only -> EMPTY; upstream transfer only -> FULL, new instruction enters skid.
REQ-022 FULL: downstream transfer -> ONE, skid moves to main in the same edge; no upstream transfer can occur in FULL.
REQ-023 Order shall be preserved: instructions leave in exactly the order accepted, none duplicated or dropped.
REQ-024 id_valid shall equal main-entry occupancy; outputs shall stay stable while id_valid is high and id_ready is low.
REQ-025 All id_* fields except id_valid shall be registered decodes of the main entry; when id_valid is low they shall be 0.
REQ-026 id_is_alu shall be computed at capture time and registered with the entry.
REQ-027 flush high shall force EMPTY on the next edge, overriding any simultaneous upstream or downstream transfer; the instruction offered with flush is discarded.
REQ-028 Throughput: with id_ready held high, one instruction per cycle sustained.

Reset
REQ-029 With reset high at a rising edge: state EMPTY, id_valid 0, if_ready 1, all id_* fields 0, skid contents cleared.
REQ-030 Reset shall take priority over flush and all handshakes, including mid-transfer.

Structure
REQ-031 Opcode constants (the eight ALU opcodes) and the instruction-field bit positions shall live in the shared CPU package, also used by the ALU controller.
REQ-032 A single sub-module, instr_decode (combinational field split plus is_alu), shall be instantiated for each entry's capture path; the buffer control shall be in id_stage.

Verification
REQ-033 Reset, then if_valid=1, instr=0x1B, pc=0x10, id_ready=1 -> next cycle id_valid=1, opcode=1, rd=2, rs=3, imm=0xB, is_alu=1, pc=0x10.
REQ-034 Stream 0x10..0x1F with id_ready low for cycles 3-6 -> if_ready drops after two accepts; all 16 emerge in order with no gaps once id_ready is high.
REQ-035 FULL state plus flush=1 with id_ready=1 -> next cycle id_valid=0, if_ready=1; the flushed instructions are never observed downstream.
REQ-036 Opcodes 0x0 and 0x2 and 0xA-0xF -> is_alu=0; opcodes 1 and 3-9 -> is_alu=1.
REQ-037 Reset asserted while FULL -> next cycle EMPTY, all outputs 0, if_ready=1.
REQ-038 Random if_valid/id_ready for 10k cycles against a reference queue model -> zero order, loss or duplication errors.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared CPU definitions: instruction field layout, ALU opcodes,
// decode bundle and decode-stage buffer states.
package id_stage_pkg;

    localparam int INSTR_W = 8;

    localparam int OP_HI  = 7;
    localparam int OP_LO  = 4;
    localparam int RD_HI  = 3;
    localparam int RD_LO  = 2;
    localparam int RS_HI  = 1;
    localparam int RS_LO  = 0;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_SHR = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1001;

    // Encoding follows occupancy: bit0 = main entry, bit1 = skid entry
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [3:0] imm;
        logic       is_alu;
    } dec_t;

    function automatic logic is_alu_op(
        input logic [3:0] op
    );
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SHL, OP_SHR, OP_CMP:
                r = 1'b1;
            default:
                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_stage_instr_decode.sv
// Combinational instruction field split plus ALU-class flag,
// used on the capture path of each decode-buffer entry.
module instr_decode
    import id_stage_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output dec_t               dec
);

    always_comb begin
        dec        = '0;
        dec.opcode = instr[OP_HI:OP_LO];
        dec.rd     = instr[RD_HI:RD_LO];
        dec.rs     = instr[RS_HI:RS_LO];
        dec.imm    = instr[IMM_HI:IMM_LO];
        dec.is_alu = is_alu_op(instr[OP_HI:OP_LO]);
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: two-entry skid buffer (main + skid) with a registered
// if_ready, decoding each instruction as it is captured.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int PC_WIDTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                if_valid,
    input  logic [INSTR_W-1:0]  if_instr,
    input  logic [PC_WIDTH-1:0] if_pc,
    output logic                if_ready,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [3:0]          id_opcode,
    output logic [1:0]          id_rd,
    output logic [1:0]          id_rs,
    output logic [3:0]          id_imm,
    output logic [PC_WIDTH-1:0] id_pc,
    output logic                id_is_alu
);

    state_t state, state_nxt;

    dec_t dec_main_in, dec_skid_in;
    dec_t main_dec, skid_dec;

    logic [PC_WIDTH-1:0] main_pc, skid_pc;

    logic up, dn;
    logic ld_main, ld_skid, mv_skid;
    logic clr_main, clr_skid;

    instr_decode u_dec_main (
        .instr (if_instr),
        .dec   (dec_main_in)
    );

    instr_decode u_dec_skid (
        .instr (if_instr),
        .dec   (dec_skid_in)
    );

    assign id_valid = state[0];
    assign up       = if_valid & if_ready;
    assign dn       = id_valid & id_ready;

    // if_ready is registered from the next state so it never
    // depends combinationally on id_ready
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_EMPTY;
            if_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            if_ready <= (state_nxt != ST_FULL);
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: if (up) state_nxt = ST_ONE;
                ST_ONE: begin
                    if (up && !dn)      state_nxt = ST_FULL;
                    else if (!up && dn) state_nxt = ST_EMPTY;
                end
                ST_FULL:  if (dn) state_nxt = ST_ONE;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        ld_main  = 1'b0;
        ld_skid  = 1'b0;
        mv_skid  = 1'b0;
        clr_main = 1'b0;
        clr_skid = 1'b0;
        if (flush) begin
            clr_main = 1'b1;
            clr_skid = 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: ld_main = up;
                ST_ONE: begin
                    ld_main  = up & dn;
                    ld_skid  = up & ~dn;
                    clr_main = dn & ~up;
                end
                ST_FULL: begin
                    mv_skid  = dn;
                    clr_skid = dn;
                end
                default: begin
                    clr_main = 1'b1;
                    clr_skid = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            main_dec <= '0;
            main_pc  <= '0;
            skid_dec <= '0;
            skid_pc  <= '0;
        end else begin
            if (ld_main) begin
                main_dec <= dec_main_in;
                main_pc  <= if_pc;
            end else if (mv_skid) begin
                main_dec <= skid_dec;
                main_pc  <= skid_pc;
            end else if (clr_main) begin
                main_dec <= '0;
                main_pc  <= '0;
            end
            if (ld_skid) begin
                skid_dec <= dec_skid_in;
                skid_pc  <= if_pc;
            end else if (clr_skid) begin
                skid_dec <= '0;
                skid_pc  <= '0;
            end
        end
    end

    assign id_opcode = main_dec.opcode;
    assign id_rd     = main_dec.rd;
    assign id_rs     = main_dec.rs;
    assign id_imm    = main_dec.imm;
    assign id_is_alu = main_dec.is_alu;
    assign id_pc     = main_pc;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage against a queue-based
// model of the accepted-but-not-yet-consumed instructions.
module tb_id_stage;

    localparam int PW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          if_valid = 1'b0;
    logic [7:0]    if_instr = '0;
    logic [PW-1:0] if_pc = '0;
    logic          if_ready;
    logic          id_valid;
    logic          id_ready = 1'b0;
    logic [3:0]    id_opcode;
    logic [1:0]    id_rd;
    logic [1:0]    id_rs;
    logic [3:0]    id_imm;
    logic [PW-1:0] id_pc;
    logic          id_is_alu;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [7:0]    instr;
        logic [PW-1:0] pc;
    } item_t;

    item_t mq[$];

    logic [22:0] obs;
    assign obs = {id_valid, if_ready, id_opcode, id_rd,
                  id_rs, id_imm, id_pc, id_is_alu};

    always #5 clock = ~clock;

    id_stage #(.PC_WIDTH(PW)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .if_ready  (if_ready),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_opcode (id_opcode),
        .id_rd     (id_rd),
        .id_rs     (id_rs),
        .id_imm    (id_imm),
        .id_pc     (id_pc),
        .id_is_alu (id_is_alu)
    );

    function automatic logic alu_class(input int op);
        return op inside {1, 3, 4, 5, 6, 7, 8, 9};
    endfunction

    // Expected observable vector derived from the queue contents
    function automatic logic [22:0] exp_vec();
        logic [22:0] v;
        int          ins;
        v = '0;
        v[21] = (mq.size() < 2);
        if (mq.size() > 0) begin
            ins = int'(mq[0].instr);
            v[22]    = 1'b1;
            v[20:17] = 4'((ins / 16) % 16);
            v[16:15] = 2'((ins / 4) % 4);
            v[14:13] = 2'(ins % 4);
            v[12:9]  = 4'(ins % 16);
            v[8:1]   = mq[0].pc;
            v[0]     = alu_class((ins / 16) % 16);
        end
        return v;
    endfunction

    // Advance one clock, updating the model with this cycle's transfers
    task automatic tick();
        bit up, dn;
        up = if_valid && (mq.size() < 2);
        dn = id_ready && (mq.size() > 0);
        if (reset || flush) begin
            mq.delete();
        end else begin
            if (dn) void'(mq.pop_front());
            if (up) mq.push_back({if_instr, if_pc});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        reset    = 1'b0;
        flush    = 1'b0;
        if_valid = 1'b0;
        id_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [22:0] e;
        do_reset();
        e = 23'h200000;
        checks++;
        if (obs !== e) begin
            fails++;
            $display("FAIL reset_state got %h want %h", obs, e);
        end
        checks++;
        if (obs !== exp_vec()) begin
            fails++;
            $display("FAIL reset_model got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_single();
        logic [22:0] e;
        do_reset();
        if_valid = 1'b1;
        if_instr = 8'h1B;
        if_pc    = 8'h10;
        id_ready = 1'b1;
        tick();
        if_valid = 1'b0;
        e = {1'b1, 1'b1, 4'h1, 2'd2, 2'd3, 4'hB, 8'h10, 1'b1};
        checks++;
        if (obs !== e) begin
            fails++;
            $display("FAIL single_decode got %h want %h", obs, e);
        end
        tick();
        checks++;
        if (id_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_drain got %b want 0", id_valid);
        end
    endtask

    task automatic test_stall_stream();
        logic [7:0] got[$];
        int nxt;
        int c;
        do_reset();
        nxt = 0;
        c   = 0;
        while (got.size() < 16 && c < 60) begin
            id_ready = !(c >= 3 && c <= 6);
            if_valid = (nxt < 16);
            if_instr = 8'(8'h10 + nxt);
            if_pc    = 8'(nxt);
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL stream_c%0d got %h want %h",
                         c, obs, exp_vec());
            end
            if (c == 4) begin
                checks++;
                if (if_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL stream_full got %b want 0", if_ready);
                end
            end
            if (c >= 7) begin
                checks++;
                if (id_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL stream_gap_c%0d got %b want 1",
                             c, id_valid);
                end
            end
            if (id_valid && id_ready)
                got.push_back({id_opcode, id_imm});
            if (if_valid && mq.size() < 2) nxt++;
            tick();
            c++;
        end
        idle_inputs();
        checks++;
        if (got.size() != 16) begin
            fails++;
            $display("FAIL stream_count got %0d want 16", got.size());
        end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            checks++;
            if (got[i] !== 8'(8'h10 + i)) begin
                fails++;
                $display("FAIL stream_order_%0d got %h want %h",
                         i, got[i], 8'(8'h10 + i));
            end
        end
    endtask

    task automatic fill_full();
        do_reset();
        id_ready = 1'b0;
        if_valid = 1'b1;
        if_instr = 8'h35;
        if_pc    = 8'h20;
        tick();
        if_instr = 8'h47;
        if_pc    = 8'h21;
        tick();
        if_valid = 1'b0;
        checks++;
        if ({id_valid, if_ready} !== 2'b10) begin
            fails++;
            $display("FAIL full_state got %b%b want 10",
                     id_valid, if_ready);
        end
    endtask

    task automatic test_flush_full();
        fill_full();
        flush    = 1'b1;
        id_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = 8'h99;
        if_pc    = 8'h22;
        tick();
        flush    = 1'b0;
        if_valid = 1'b0;
        checks++;
        if ({id_valid, if_ready} !== 2'b01) begin
            fails++;
            $display("FAIL flush_state got %b%b want 01",
                     id_valid, if_ready);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== 23'h200000) begin
                fails++;
                $display("FAIL flush_leak_%0d got %h want 200000",
                         i, obs);
            end
            tick();
        end
    endtask

    task automatic test_is_alu();
        logic [15:0] mask;
        mask = 16'h03FA;
        do_reset();
        id_ready = 1'b1;
        for (int op = 0; op < 16; op++) begin
            if_valid = 1'b1;
            if_instr = {4'(op), 4'($urandom_range(0, 15))};
            if_pc    = 8'($urandom);
            tick();
            checks++;
            if (id_is_alu !== mask[op] || obs !== exp_vec()) begin
                fails++;
                $display("FAIL is_alu_op%0d got %b want %b",
                         op, id_is_alu, mask[op]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_full();
        fill_full();
        reset    = 1'b1;
        flush    = 1'b1;
        if_valid = 1'b1;
        id_ready = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (obs !== 23'h200000) begin
            fails++;
            $display("FAIL reset_full got %h want 200000", obs);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            if_valid = ($urandom_range(0, 3) != 0);
            id_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 99) == 0);
            if_instr = 8'($urandom);
            if_pc    = 8'($urandom);
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL random_c%0d got %h want %h",
                         c, obs, exp_vec());
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall_stream();
        test_flush_full();
        test_is_alu();
        test_reset_full();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
